// File: rtl/prog_loader.sv
// Program loader: streams words into instruction memory, zero-fills the remainder,
// then releases the core from reset and supervises its run until halt or budget expiry.
module prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MAX_RUN = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              core_stall,
    input  logic              halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       run_cycles
);
    localparam int              CNT_W      = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL_COUNT = CNT_W'(2 ** ADDR_W);
    localparam logic [31:0]     RUN_LAST   = 32'(MAX_RUN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_RELEASE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              xfer, at_top, begin_load, budget_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        xfer       = (state == S_LOAD) && in_valid;
        at_top     = (ptr == '1);
        begin_load = start && ((state == S_IDLE) || (state == S_DONE));
        budget_out = (run_cycles == RUN_LAST);
        in_ready   = (state == S_LOAD);
        busy       = (state == S_LOAD) || (state == S_FILL) ||
                     (state == S_RELEASE) || (state == S_RUN);
        done       = (state == S_DONE);
        core_stall = (state == S_DONE);
        // The core sees reset everywhere except while running and while parked in DONE.
        core_rst   = !((state == S_RUN) || (state == S_DONE));
        case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (xfer) begin
                    if (at_top)       state_nxt = in_last ? S_RELEASE : S_IDLE;
                    else if (in_last) state_nxt = S_FILL;
                end
            end
            S_FILL:    if (at_top) state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_RUN;
            S_RUN:     if (halt || budget_out) state_nxt = S_DONE;
            S_DONE:    if (start) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            run_cycles   <= '0;
            timeout      <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (begin_load) begin
                ptr          <= '0;
                word_count   <= '0;
                run_cycles   <= '0;
                timeout      <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (xfer) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= in_data;
                ptr       <= ptr + 1'b1;
                if (word_count != FULL_COUNT) word_count <= word_count + 1'b1;
                if (at_top && !in_last)       err_overflow <= 1'b1;
            end
            if (state == S_FILL) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= '0;
                ptr       <= ptr + 1'b1;
            end
            // The exit cycle of RUN is not counted, so a budget stop reads MAX_RUN-1.
            if (state == S_RUN && !halt) begin
                if (budget_out) timeout    <= 1'b1;
                else            run_cycles <= run_cycles + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a memory/run reference model and a small GCD core stand-in.
module tb_prog_loader;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int MAX_RUN = 20;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int LOG_N   = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready, mem_we, core_rst, core_stall, busy, done, timeout, err_overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       run_cycles;
    logic              halt;
    logic              halt_drv = 1'b0;
    logic              gcd_mode = 1'b0;
    logic              gcd_halt;
    logic [31:0]       ga = 32'd0;
    logic [31:0]       gb = 32'd0;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .core_rst(core_rst), .core_stall(core_stall), .halt(halt),
        .busy(busy), .done(done), .timeout(timeout), .err_overflow(err_overflow),
        .word_count(word_count), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] words   [DEPTH];
    logic [DATA_W-1:0] tb_mem  [DEPTH];
    logic [ADDR_W-1:0] wr_addr [LOG_N];
    logic [DATA_W-1:0] wr_data [LOG_N];
    int   wr_n = 0, nedge = 0, fall_edge = -1, top_edge = -1;
    logic prev_core_rst = 1'b1;

    // Write log and memory image, plus the edge where core_rst falls.
    always @(negedge clk) begin
        nedge         <= nedge + 1;
        prev_core_rst <= core_rst;
        if (prev_core_rst && !core_rst) fall_edge <= nedge;
        if (mem_we) begin
            if (wr_n < LOG_N) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_wdata;
            end
            wr_n             <= wr_n + 1;
            tb_mem[mem_addr] <= mem_wdata;
            if (mem_addr == ADDR_W'(DEPTH - 1)) top_edge <= nedge;
        end
    end

    // Stand-in core: subtractive GCD of dm[0]=48, dm[1]=18, result kept in "register 30" (ga).
    always @(posedge clk) begin
        if (core_rst) begin
            ga <= 32'd48;
            gb <= 32'd18;
        end else if (!core_stall) begin
            if (ga > gb)      ga <= ga - gb;
            else if (gb > ga) gb <= gb - ga;
        end
    end
    assign gcd_halt = !core_rst && (ga == gb);
    assign halt     = gcd_mode ? gcd_halt : halt_drv;

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_steps(input int a, input int b);
        int s = 0;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            s++;
        end
        return s;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input logic last, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 8; t++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drives halt on the halt_at-th RUN cycle (0-based); negative means never.
    task automatic run_core(input int halt_at, output bit ok, output int run_seen);
        ok       = 1'b0;
        run_seen = 0;
        halt_drv = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (core_rst === 1'b0) begin
                halt_drv = (run_seen == halt_at);
                run_seen++;
            end
            @(negedge clk);
        end
        halt_drv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_we, busy, done, timeout, err_overflow, core_stall, core_rst} !== 8'b0000_0001)
            $display("FAIL reset_flags got %b want 00000001",
                     {in_ready, mem_we, busy, done, timeout, err_overflow, core_stall, core_rst});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, word_count, run_cycles} !== '0)
            $display("FAIL reset_counts addr=%0h wdata=%0h wc=%0d rc=%0d want all 0",
                     mem_addr, mem_wdata, word_count, run_cycles);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, core_rst, in_ready} !== 4'b0010)
            $display("FAIL idle_hold got %b want 0010", {busy, done, core_rst, in_ready});
        else n_pass++;
    endtask

    task automatic test_load_fill(input int n, input bit toggle, input int halt_at,
                                  input bit directed, input string tag);
        bit ok;
        int run_seen, base, bad, first_bad, ready_bad, xfer_bad, exp_rc;
        bit exp_to;
        logic [DATA_W-1:0] exp_mem [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            words[i]   = directed ? DATA_W'(32'h11 + i) : DATA_W'($urandom);
            exp_mem[i] = (i < n) ? words[i] : '0;
        end
        if (halt_at >= 0 && halt_at < MAX_RUN) begin
            exp_rc = halt_at;
            exp_to = 1'b0;
        end else begin
            exp_rc = MAX_RUN - 1;
            exp_to = 1'b1;
        end
        base = wr_n;
        pulse_start();
        n_checks++;
        if ({done, core_stall, core_rst, busy, in_ready} !== 5'b00111)
            $display("FAIL %s after_start got %b want 00111", tag,
                     {done, core_stall, core_rst, busy, in_ready});
        else n_pass++;
        ready_bad = 0;
        xfer_bad  = 0;
        for (int i = 0; i < n; i++) begin
            if (toggle) begin
                in_valid = 1'b0;
                @(negedge clk);
                if (in_ready !== 1'b1) ready_bad++;
            end
            send_word(words[i], (i == n - 1), ok);
            if (!ok) xfer_bad++;
        end
        n_checks++;
        if (ready_bad != 0 || xfer_bad != 0)
            $display("FAIL %s ready_in_load low_bubbles=%0d refused=%0d want 0/0", tag, ready_bad, xfer_bad);
        else n_pass++;
        run_core(halt_at, ok, run_seen);
        n_checks++;
        if (!ok) $display("FAIL %s done_reached got done=%b want 1 within budget", tag, done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (wr_n - base != DEPTH) $display("FAIL %s write_count got %0d want %0d", tag, wr_n - base, DEPTH);
        else n_pass++;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < DEPTH && base + i < wr_n; i++)
            if (wr_addr[base + i] !== ADDR_W'(i) || wr_data[base + i] !== exp_mem[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        n_checks++;
        if (bad != 0) $display("FAIL %s write_seq got %0d bad entries (first %0d) want 0", tag, bad, first_bad);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== exp_mem[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL %s mem_image got %0d bad words want 0", tag, bad);
        else n_pass++;
        n_checks++;
        if (int'(word_count) != n) $display("FAIL %s word_count got %0d want %0d", tag, word_count, n);
        else n_pass++;
        n_checks++;
        if (fall_edge != top_edge + 1)
            $display("FAIL %s core_rst_fall got edge %0d want %0d", tag, fall_edge, top_edge + 1);
        else n_pass++;
        n_checks++;
        if (run_cycles !== 32'(exp_rc) || timeout !== exp_to)
            $display("FAIL %s run_result got rc=%0d to=%b want rc=%0d to=%b", tag, run_cycles, timeout, exp_rc, exp_to);
        else n_pass++;
        n_checks++;
        if (run_seen != exp_rc + 1) $display("FAIL %s run_length got %0d want %0d", tag, run_seen, exp_rc + 1);
        else n_pass++;
        n_checks++;
        if ({done, core_stall, core_rst, busy, err_overflow} !== 5'b11000)
            $display("FAIL %s done_state got %b want 11000", tag, {done, core_stall, core_rst, busy, err_overflow});
        else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        int base, bad, ready_bad, xfer_bad;
        base = wr_n;
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        pulse_start();
        xfer_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_word(words[i], 1'b0, ok);
            if (!ok) xfer_bad++;
        end
        in_valid  = 1'b1;
        in_data   = $urandom;
        in_last   = 1'b0;
        ready_bad = 0;
        repeat (4) begin
            if (in_ready !== 1'b0) ready_bad++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (xfer_bad != 0 || ready_bad != 0)
            $display("FAIL ovf_handshake refused=%0d ready_after=%0d want 0/0", xfer_bad, ready_bad);
        else n_pass++;
        n_checks++;
        if (err_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", err_overflow);
        else n_pass++;
        n_checks++;
        if (wr_n - base != DEPTH) $display("FAIL ovf_write_count got %0d want %0d", wr_n - base, DEPTH);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < DEPTH && base + i < wr_n; i++)
            if (wr_addr[base + i] !== ADDR_W'(i) || wr_data[base + i] !== words[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL ovf_write_seq got %0d bad entries want 0", bad);
        else n_pass++;
        n_checks++;
        if (int'(word_count) != DEPTH) $display("FAIL ovf_word_count got %0d want %0d", word_count, DEPTH);
        else n_pass++;
        n_checks++;
        if ({busy, done, core_rst, core_stall} !== 4'b0010)
            $display("FAIL ovf_idle got %b want 0010", {busy, done, core_rst, core_stall});
        else n_pass++;
    endtask

    task automatic test_gcd();
        bit ok;
        int run_seen;
        gcd_mode = 1'b1;
        pulse_start();
        for (int i = 0; i < 6; i++) send_word(DATA_W'($urandom), (i == 5), ok);
        run_core(-1, ok, run_seen);
        n_checks++;
        if (!ok || done !== 1'b1 || timeout !== 1'b0)
            $display("FAIL gcd_done got done=%b timeout=%b want 1/0", done, timeout);
        else n_pass++;
        n_checks++;
        if (run_cycles !== 32'(ref_steps(48, 18)))
            $display("FAIL gcd_run_cycles got %0d want %0d", run_cycles, ref_steps(48, 18));
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ga !== 32'(ref_gcd(48, 18)) || core_stall !== 1'b1 || core_rst !== 1'b0 || done !== 1'b1)
            $display("FAIL gcd_result got r30=%0d stall=%b core_rst=%b want %0d/1/0",
                     ga, core_stall, core_rst, ref_gcd(48, 18));
        else n_pass++;
        gcd_mode = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom), (i == 2), ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({busy, in_ready, mem_we} !== 3'b101)
            $display("FAIL fill_start_ignored got %b want 101", {busy, in_ready, mem_we});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_we, busy, done, timeout, err_overflow, core_stall, core_rst} !== 8'b0000_0001)
            $display("FAIL midfill_reset_flags got %b want 00000001",
                     {in_ready, mem_we, busy, done, timeout, err_overflow, core_stall, core_rst});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, word_count, run_cycles} !== '0)
            $display("FAIL midfill_reset_counts addr=%0h wdata=%0h wc=%0d rc=%0d want all 0",
                     mem_addr, mem_wdata, word_count, run_cycles);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_fill(5, 1'b0, 7, 1'b1, "plan_stream");
        test_load_fill(5, 1'b1, 3, 1'b1, "plan_toggle");
        test_overflow();
        test_gcd();
        test_load_fill($urandom_range(1, 15), 1'b0, -1, 1'b0, "timeout");
        test_load_fill(DEPTH, 1'b0, MAX_RUN - 1, 1'b0, "full_depth_halt_at_limit");
        test_load_fill(1, 1'b1, 0, 1'b0, "halt_first_cycle");
        test_reset_mid_fill();
        test_load_fill(4, 1'b0, 2, 1'b0, "reload_after_reset");
        for (int k = 0; k < 4; k++)
            test_load_fill($urandom_range(1, DEPTH), ($urandom_range(0, 1) == 1),
                           $urandom_range(0, 24), 1'b0, "random");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream companion to the KGP-RISC Datapath.
- Accepts a program as a stream of 32-bit words over a valid/ready handshake and writes it sequentially into instruction memory through the memory write port.
- Zero-fills the unused remainder of instruction memory, then releases the core from reset and runs it until halt or a cycle budget expires.
- Reports completion and the run-cycle count so benches no longer depend on fixed-delay waits.

Parameters:
- ADDR_W, 10, instruction memory address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, instruction word width.
- MAX_RUN, 1000, cycle budget for RUN before forced stop.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE or DONE.
- in_valid  input  1  input word valid.
- in_data  input  DATA_W  instruction word.
- in_last  input  1  marks the final program word; qualified by in_valid.
- in_ready  output  1  loader accepts a word this cycle.
- mem_we  output  1  instruction memory write enable (registered).
- mem_addr  output  ADDR_W  write address (registered).
- mem_wdata  output  DATA_W  write data (registered).
- core_rst  output  1  active-high reset to the Datapath.
- core_stall  output  1  freezes the core while it is out of reset; registers are retained.
- halt  input  1  core halt indication.
- busy  output  1  high in LOAD, FILL, RELEASE and RUN.
- done  output  1  high in DONE.
- timeout  output  1  RUN ended by budget expiry, not by halt.
- err_overflow  output  1  program exceeded DEPTH words.
- word_count  output  ADDR_W+1  words accepted in the last load.
- run_cycles  output  32  cycles spent in RUN.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - State = IDLE.
  - in_ready, mem_we, busy, done, timeout, err_overflow, core_stall = 0.
  - mem_addr, mem_wdata, word_count, run_cycles = 0.
  - core_rst = 1.
  - Reset mid-load or mid-run aborts immediately with the same values; partially written memory is not cleaned.
- States: IDLE, LOAD, FILL, RELEASE, RUN, DONE.
- IDLE:
  - core_rst=1.
  - start -> LOAD; clears ptr, word_count, err_overflow, timeout and run_cycles.
- LOAD:
  - in_ready = 1 combinationally; transfer occurs when in_valid & in_ready.
  - On transfer: the next cycle drives mem_we=1, mem_addr=ptr, mem_wdata=in_data (1-cycle latency); ptr and word_count increment.
  - Transfer with in_last at ptr < DEPTH-1 -> FILL.
  - Transfer with in_last at ptr == DEPTH-1 -> RELEASE; no FILL, no error.
  - Transfer at ptr == DEPTH-1 without in_last -> err_overflow=1, in_ready drops, state -> IDLE; core_rst stays 1 and the core never runs.
  - in_valid=0 stalls LOAD indefinitely; no timeout.
- FILL:
  - in_ready=0.
  - Each cycle writes 0 at ptr and increments ptr; after the DEPTH-1 write -> RELEASE.
  - Fill takes DEPTH - word_count cycles.
- RELEASE: one cycle, core_rst still 1; next cycle core_rst=0 and state = RUN.
- RUN:
  - run_cycles increments every cycle.
  - halt=1 -> DONE.
  - If run_cycles == MAX_RUN-1 without halt -> DONE with timeout=1.
  - halt and budget expiry in the same cycle: halt takes priority, timeout=0.
- DONE:
  - core_stall=1, core_rst=0, so core state remains readable.
  - done=1; run_cycles and word_count hold.
  - start -> core_rst=1, core_stall=0, done=0, -> LOAD.
- start is ignored in LOAD, FILL, RELEASE and RUN.
- Counter widths: word_count saturates at DEPTH; run_cycles never wraps because MAX_RUN < 2**32.

Test Plan:
1. ADDR_W=4, start, stream 5 words 0x11..0x15 with in_last on the 5th -> writes addr 0..4 with 0x11..0x15, then zeros at addr 5..15; word_count=5; core_rst falls 1 cycle after the addr-15 write.
2. Same setup with in_valid toggling every other cycle -> identical memory contents; in_ready high throughout LOAD.
3. ADDR_W=4, 17 words with no in_last -> err_overflow=1 after the 16th word; no 17th write; state IDLE; core_rst=1.
4. GCD program loaded with dm[0]=48, dm[1]=18; halt asserted by the core -> done=1, timeout=0, register[30]=6 readable while core_stall=1.
5. MAX_RUN=20 with halt tied to 0 -> done after 20 RUN cycles, timeout=1, run_cycles=19.
6. Drive rst=0 for one cycle midway through FILL -> all outputs return to reset values in the same cycle; a new start reloads correctly.
